// File: rtl/dma_wr_arbiter.sv
// Purpose : round-robin arbiter sharing one FIFO write port among NUM_REQ burst requesters.
// Latency : one arbitration cycle in IDLE, then one word per cycle while the FIFO is not full.
// Backpr. : fifo_full drops req_ready of the owner; a stalled owner is released by a watchdog.
//
// Ports:
//   clk, srst                     clock; asynchronous active-high reset
//   req_valid/req_data/req_last   per-requester word stream (requester i owns req_data[i*DW +: DW])
//   req_ready                     word accepted this cycle (one-hot or zero)
//   fifo_wr_en/fifo_din/fifo_full FIFO write port
//   grant_id, busy                current owner (valid while busy) and grant-held flag
//   err_abort                     one-cycle pulse when the watchdog aborts a burst
//   burst_cnt                     completed bursts, wrapping 16-bit counter
module dma_wr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16,
    localparam int GW     = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*DW-1:0] req_data,
    input  logic [NUM_REQ-1:0]    req_last,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  fifo_wr_en,
    output logic [DW-1:0]         fifo_din,
    input  logic                  fifo_full,
    output logic [GW-1:0]         grant_id,
    output logic                  busy,
    output logic                  err_abort,
    output logic [15:0]           burst_cnt
);

    localparam int IW = $clog2(TIMEOUT);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_XFER = 1'b1;

    logic [0:0]    state;
    logic [GW-1:0] rr_ptr;
    logic [IW-1:0] idle_cnt;

    logic [GW-1:0] pick;
    logic          any_req;
    logic [GW-1:0] next_ptr;
    logic          g_valid;
    logic          g_last;
    logic [DW-1:0] g_data;
    logic          in_xfer;
    logic          fire;

    // Rotating priority search: first valid index starting at rr_ptr.
    always_comb begin : arb
        int idx;
        idx     = 0;
        pick    = '0;
        any_req = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!any_req && req_valid[idx]) begin
                pick    = GW'(idx);
                any_req = 1'b1;
            end
        end
    end

    // Owner's signals and the pointer that follows it.
    assign g_valid  = req_valid[grant_id];
    assign g_last   = req_last[grant_id];
    assign g_data   = req_data[grant_id*DW +: DW];
    assign next_ptr = (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + GW'(1);

    assign in_xfer    = (state == S_XFER);
    assign busy       = in_xfer;
    assign fire       = in_xfer & g_valid & ~fifo_full;
    assign fifo_wr_en = fire;
    assign fifo_din   = in_xfer ? g_data : '0;

    always_comb begin
        req_ready = '0;
        if (in_xfer) begin
            req_ready[grant_id] = ~fifo_full;
        end
    end

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            grant_id  <= '0;
            idle_cnt  <= '0;
            burst_cnt <= '0;
            err_abort <= 1'b0;
        end else begin
            err_abort <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        grant_id <= pick;
                        idle_cnt <= '0;
                        state    <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (g_valid) begin
                        // A valid word held back by a full FIFO is not idleness.
                        idle_cnt <= '0;
                        if (fire && g_last) begin
                            state     <= S_IDLE;
                            rr_ptr    <= next_ptr;
                            burst_cnt <= burst_cnt + 16'd1;
                        end
                    end else if (idle_cnt == IW'(TIMEOUT - 1)) begin
                        // Owner stalled mid-burst: release the port, count nothing.
                        err_abort <= 1'b1;
                        idle_cnt  <= '0;
                        rr_ptr    <= next_ptr;
                        state     <= S_IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + IW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_wr_arbiter.sv
// Purpose : directed bench for dma_wr_arbiter with a word-queue requester model and a 4-deep FIFO model.
// Latency : writes are logged by the clock edge that commits them.
// Backpr. : FIFO occupancy model drives fifo_full; pops are controlled per test.
module tb_dma_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int TO = 16;
    localparam int GW = $clog2(NR);

    logic              clk = 1'b0;
    logic              srst;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_last;
    logic [NR-1:0]     req_ready;
    logic              fifo_wr_en;
    logic [DW-1:0]     fifo_din;
    logic              fifo_full;
    logic [GW-1:0]     grant_id;
    logic              busy;
    logic              err_abort;
    logic [15:0]       burst_cnt;

    always #5 clk = ~clk;

    dma_wr_arbiter #(.NUM_REQ(NR), .DW(DW), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .srst       (srst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .fifo_full  (fifo_full),
        .grant_id   (grant_id),
        .busy       (busy),
        .err_abort  (err_abort),
        .burst_cnt  (burst_cnt)
    );

    // Requester model: each requester streams words[i][0..len-1].
    logic [31:0] words [NR][16];
    int          len    [NR];
    int          ptr    [NR];
    bit          en     [NR];
    bit          nolast [NR];
    bit          single [NR];

    int  fifo_cnt;
    bit  pop_en;
    int  cyc_n = 0;
    int  full_viol;

    logic [31:0] wr_dat  [$];
    int          wr_edge [$];
    int          err_edge[$];

    int n_checks = 0;
    int n_errors = 0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] get_dat(input int k);
        return (k < wr_dat.size()) ? wr_dat[k] : 32'hDEAD_BEEF;
    endfunction

    function automatic int get_edge(input int k);
        return (k < wr_edge.size()) ? wr_edge[k] : -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            req_valid[i]           = 1'b0;
            req_last[i]            = 1'b0;
            req_data[i*DW +: DW]   = '0;
            if (en[i] && ptr[i] < len[i]) begin
                req_valid[i]         = 1'b1;
                req_data[i*DW +: DW] = words[i][ptr[i]];
                req_last[i]          = !nolast[i] && (single[i] || ptr[i] == len[i] - 1);
            end
        end
        fifo_full = (fifo_cnt >= 4);
    endtask

    // Sample the current cycle at the falling edge, then advance one clock.
    task automatic tick();
        @(negedge clk);
        if (fifo_wr_en) begin
            wr_dat.push_back(fifo_din);
            wr_edge.push_back(cyc_n + 1);
        end
        if (err_abort) err_edge.push_back(cyc_n);
        if (fifo_full && (fifo_wr_en || req_ready != '0)) full_viol++;
        for (int i = 0; i < NR; i++)
            if (req_ready[i] && req_valid[i]) ptr[i]++;
        fifo_cnt = fifo_cnt + (fifo_wr_en ? 1 : 0) - ((pop_en && fifo_cnt > 0) ? 1 : 0);
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic rst_on();
        srst = 1'b1;
        for (int i = 0; i < NR; i++) begin
            en[i] = 0; nolast[i] = 0; single[i] = 0; ptr[i] = 0; len[i] = 0;
        end
        pop_en   = 1'b1;
        fifo_cnt = 0;
        drive();
    endtask

    task automatic rst_off();
        repeat (2) @(posedge clk);
        #1;
        srst = 1'b0;
        wr_dat.delete();
        wr_edge.delete();
        err_edge.delete();
        full_viol = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int c0, c1, c2, p;

        // Reset state
        rst_on();
        rst_off();
        #1;
        check("rst_busy",      busy,       0);
        check("rst_grant",     grant_id,   0);
        check("rst_burst_cnt", burst_cnt,  0);
        check("rst_ready",     req_ready,  0);
        check("rst_wr_en",     fifo_wr_en, 0);
        check("rst_din",       fifo_din,   0);
        check("rst_err",       err_abort,  0);

        // 1: req1 sends A,B,C; commits on the 2nd, 3rd, 4th edges after valid rises
        @(posedge clk); #1;
        words[1][0] = 32'h1111_000A; words[1][1] = 32'h1111_000B; words[1][2] = 32'h1111_000C;
        len[1] = 3; en[1] = 1;
        drive();
        c0 = cyc_n;
        tick();
        check("t1_busy",  busy,      1);
        check("t1_grant", grant_id,  1);
        check("t1_ready", req_ready, 4'b0010);
        repeat (5) tick();
        check("t1_nwr",   wr_dat.size(), 3);
        check("t1_d0",    get_dat(0), 32'h1111_000A);
        check("t1_d1",    get_dat(1), 32'h1111_000B);
        check("t1_d2",    get_dat(2), 32'h1111_000C);
        check("t1_e0",    get_edge(0), c0 + 2);
        check("t1_e2",    get_edge(2), c0 + 4);
        check("t1_bcnt",  burst_cnt, 1);
        check("t1_idle",  busy, 0);

        // 2: req0 and req2 valid at reset release, 2 words each
        rst_on();
        words[0][0] = 32'h0000_00A0; words[0][1] = 32'h0000_00A1; len[0] = 2; en[0] = 1;
        words[2][0] = 32'h2222_00B0; words[2][1] = 32'h2222_00B1; len[2] = 2; en[2] = 1;
        drive();
        rst_off();
        c0 = cyc_n;
        repeat (10) tick();
        check("t2_nwr", wr_dat.size(), 4);
        check("t2_d0",  get_dat(0), 32'h0000_00A0);
        check("t2_d1",  get_dat(1), 32'h0000_00A1);
        check("t2_d2",  get_dat(2), 32'h2222_00B0);
        check("t2_d3",  get_dat(3), 32'h2222_00B1);
        check("t2_e1",  get_edge(1), c0 + 3);
        check("t2_e2",  get_edge(2), c0 + 5);
        check("t2_bcnt", burst_cnt, 2);

        // 3: req3 sends 6 words, FIFO not popped; full held longer than the watchdog
        rst_on();
        rst_off();
        pop_en = 0;
        for (int k = 0; k < 6; k++) words[3][k] = 32'h3333_0000 + k;
        len[3] = 6; en[3] = 1;
        drive();
        repeat (24) tick();
        check("t3_nwr_full", wr_dat.size(), 4);
        check("t3_full",     fifo_full, 1);
        check("t3_ready",    req_ready, 0);
        check("t3_wr_en",    fifo_wr_en, 0);
        check("t3_busy",     busy, 1);
        check("t3_no_abort", err_edge.size(), 0);
        pop_en = 1;
        p = cyc_n;
        tick();
        pop_en = 0;
        tick();
        check("t3_nwr_pop1", wr_dat.size(), 5);
        check("t3_e4",       get_edge(4), p + 2);
        repeat (3) tick();
        check("t3_nwr_hold", wr_dat.size(), 5);
        pop_en = 1;
        repeat (4) tick();
        check("t3_nwr_all",  wr_dat.size(), 6);
        for (int k = 0; k < 6; k++) check($sformatf("t3_d%0d", k), get_dat(k), 32'h3333_0000 + k);
        check("t3_bcnt",     burst_cnt, 1);
        check("t3_full_viol", full_viol, 0);

        // 4: req2 sends one word without last, then stalls
        rst_on();
        rst_off();
        words[2][0] = 32'h2222_0001; len[2] = 1; nolast[2] = 1; en[2] = 1;
        drive();
        c0 = cyc_n;
        repeat (TO + 5) tick();
        check("t4_nwr",    wr_dat.size(), 1);
        check("t4_nerr",   err_edge.size(), 1);
        check("t4_err_at", (err_edge.size() > 0) ? err_edge[0] : -1, c0 + 2 + TO);
        check("t4_busy",   busy, 0);
        check("t4_bcnt",   burst_cnt, 0);
        words[0][0] = 32'h0000_0F00; len[0] = 1; en[0] = 1;
        words[3][0] = 32'h3333_0F03; len[3] = 1; en[3] = 1;
        drive();
        repeat (6) tick();
        check("t4_next_3", get_dat(1), 32'h3333_0F03);
        check("t4_next_0", get_dat(2), 32'h0000_0F00);

        // 5: reset during word 2 of a 4-word burst from req0 (rr_ptr was 3)
        rst_on();
        rst_off();
        words[2][0] = 32'h2222_0005; len[2] = 1; en[2] = 1;
        drive();
        repeat (4) tick();
        for (int k = 0; k < 4; k++) words[0][k] = 32'h5000_000A + k;
        len[0] = 4; en[0] = 1;
        drive();
        c1 = cyc_n;
        tick();
        tick();
        check("t5_mid_wr", fifo_wr_en, 1);
        check("t5_mid_bcnt", burst_cnt, 1);
        #2;
        srst = 1'b1;
        #1;
        check("t5_rst_busy",  busy,       0);
        check("t5_rst_wr",    fifo_wr_en, 0);
        check("t5_rst_din",   fifo_din,   0);
        check("t5_rst_ready", req_ready,  0);
        check("t5_rst_grant", grant_id,   0);
        check("t5_rst_bcnt",  burst_cnt,  0);
        words[3][0] = 32'h3333_0005; len[3] = 1; en[3] = 1; ptr[3] = 0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        srst = 1'b0;
        c2 = cyc_n;
        repeat (8) tick();
        check("t5_nwr", wr_dat.size(), 6);
        check("t5_dB",  get_dat(2), 32'h5000_000B);
        check("t5_dC",  get_dat(3), 32'h5000_000C);
        check("t5_dD",  get_dat(4), 32'h5000_000D);
        check("t5_d3",  get_dat(5), 32'h3333_0005);
        check("t5_eB",  get_edge(2), c2 + 2);
        check("t5_c1",  c2 > c1, 1);

        // 6: all requesters issue 1-word bursts continuously for 40 cycles
        rst_on();
        rst_off();
        for (int i = 0; i < NR; i++) begin
            for (int k = 0; k < 16; k++) words[i][k] = (32'(i) << 28) | 32'(k);
            len[i] = 16; single[i] = 1; en[i] = 1;
        end
        drive();
        repeat (40) tick();
        for (int i = 0; i < NR; i++) en[i] = 0;
        drive();
        repeat (3) tick();
        check("t6_nwr", wr_dat.size(), 20);
        for (int k = 0; k < 20; k++)
            check($sformatf("t6_d%0d", k), get_dat(k), (32'(k % 4) << 28) | 32'(k / 4));
        for (int i = 0; i < NR; i++) check($sformatf("t6_cnt%0d", i), ptr[i], 5);
        check("t6_bcnt", burst_cnt, 20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
